lfsr_keystream_gen: RTL and testbench
=====================================

Name: lfsr_keystream_gen

Overview:
Parametrised Fibonacci LFSR keystream generator. It is the next generation of the 7-bit programmable-tap LFSR used by the encryption datapath. It adds generic state width, asynchronous reset, multi-bit keystream words delivered over a valid/ready handshake, lock-up detection, and period-return detection. It sits between the control FSM, which seeds and configures it, and the XOR stage, which consumes KeyOut.

Parameters:
WIDTH, 7, LFSR state width in bits (>= 3).
OUT_BITS, 8, keystream bits assembled per output word (>= 1).
SEED_RST, 1, State value after reset; must be nonzero.
TAPS_RST, 'h60, Taps value after reset.

Ports:
Clk  input  1  rising-edge clock.
Reset_n  input  1  asynchronous active-low reset.
Enable  input  1  allows LFSR stepping while filling a word.
Load  input  1  loads SeedIn into State; highest priority.
SeedIn  input  WIDTH  seed value.
TapsWr  input  1  writes the tap mask.
TapsIn  input  WIDTH  tap mask, or table index under LFSR_TAP_TABLE_EN.
KeyReady  input  1  consumer accepts KeyOut.
KeyValid  output  1  KeyOut holds a complete word.
KeyOut  output  OUT_BITS  keystream word.
State  output  WIDTH  current LFSR state.
Lockup  output  1  combinational, (State == 0).
PeriodHit  output  1  one-cycle pulse when a step returns State to the last loaded seed.

Behaviour:
- Reset, asynchronous: State=SEED_RST, Taps=TAPS_RST, stored seed=SEED_RST, FSM=IDLE, bit counter=0, KeyOut=0, KeyValid=0, PeriodHit=0.
- Step: fb = ^(Taps & State); State <= {State[WIDTH-2:0], fb}; KeyOut <= {KeyOut[OUT_BITS-2:0], fb}. The first generated bit ends at the MSB of the word.
- FSM states:
  - IDLE: counter=0, KeyValid=0. Enable=1 -> FILL on the next edge. No step occurs in IDLE.
  - FILL: each cycle with Enable=1, one step and counter+1. Enable=0 pauses: State, KeyOut and counter hold. When the OUT_BITS-th step occurs, the next state is VALID and KeyValid=1 from the following cycle.
  - VALID: KeyValid=1; KeyOut, State and counter are frozen regardless of Enable. If KeyValid & KeyReady, the word is consumed: counter=0, next state is FILL if Enable else IDLE, and KeyValid drops the next cycle.
- Throughput: one word per OUT_BITS+1 cycles with Enable and KeyReady held high.
- Load, any state: State<=SeedIn, stored seed<=SeedIn, counter=0, KeyValid<=0, FSM->IDLE. Any partial or pending word is discarded. Load overrides a step in the same cycle.
- TapsWr: Taps update at the edge. A step in the same cycle uses the old Taps. A word in progress is not aborted.
- PeriodHit: asserted the cycle after any step whose new State equals the stored seed. It is not asserted on Load.
- Lockup: with State=0 every step yields fb=0, so words are 0x00. The block never self-recovers; only Load or reset clears it.
- Reset_n low mid-word or while VALID: the word is lost and all outputs return to their reset values immediately.

Optional Feature:
Macro LFSR_TAP_TABLE_EN.
- Defined: on TapsWr, TapsIn[3:0] indexes a preset table: 0:'h60 1:'h48 2:'h78 3:'h72 4:'h6A 5:'h69 6:'h5C 7:'h7E 8:'h7B. Indices 9-15 leave Taps unchanged. The table is valid for WIDTH=7 only; elaboration errors otherwise.
- Undefined: TapsIn is written directly as the raw tap mask.

Test Plan:
- Reset, then check: State=0x01, Taps=0x60, KeyValid=0, Lockup=0, PeriodHit=0.
- Defaults, Enable=1, KeyReady=0 -> KeyValid rises 9 cycles after Enable, KeyOut=0x06, State=0x06, and both hold stable for 20 cycles of backpressure.
- Seed 0x01, taps 0x60, Enable=1, KeyReady=1 continuous -> PeriodHit pulses exactly once per 127 steps, first on step 127.
- Load SeedIn=0x00 -> Lockup=1 and every subsequent word is 0x00; Load 0x01 -> Lockup=0.
- Load asserted after 3 steps of FILL -> KeyValid stays 0, State=SeedIn, and the next word is the full 8 bits computed from the new seed.
- LFSR_TAP_TABLE_EN defined: TapsWr with TapsIn=2 -> Taps=0x78; TapsIn=12 -> Taps unchanged. Without the macro, TapsIn=0x7B -> Taps=0x7B.

Source files
------------

// File: rtl/lfsr_keystream_gen.sv
// lfsr_keystream_gen: Fibonacci LFSR keystream generator.
// Feedback is the parity of (Taps & State). Each step shifts the feedback bit
// into the LSB of State and into the LSB of the keystream word being built.
// After OUT_BITS steps the word is offered on a valid/ready handshake.
// Also reports lock-up (State == 0) and return to the last loaded seed.
// Optional build macro LFSR_TAP_TABLE_EN: when defined, TapsWr treats
// TapsIn[3:0] as an index into a preset 7-bit tap table instead of a raw mask.
module lfsr_keystream_gen #(
    parameter int               WIDTH    = 7,
    parameter int               OUT_BITS = 8,
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1),
    parameter logic [WIDTH-1:0] TAPS_RST = WIDTH'('h60)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic                Load,
    input  logic [WIDTH-1:0]    SeedIn,
    input  logic                TapsWr,
    input  logic [WIDTH-1:0]    TapsIn,
    input  logic                KeyReady,
    output logic                KeyValid,
    output logic [OUT_BITS-1:0] KeyOut,
    output logic [WIDTH-1:0]    State,
    output logic                Lockup,
    output logic                PeriodHit
);

    localparam int CNT_W = (OUT_BITS > 1) ? $clog2(OUT_BITS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    // Parameter sanity checks at elaboration time.
    generate
        if (WIDTH < 3) begin : g_bad_width
            $error("lfsr_keystream_gen: WIDTH must be >= 3");
        end
        if (OUT_BITS < 1) begin : g_bad_out_bits
            $error("lfsr_keystream_gen: OUT_BITS must be >= 1");
        end
        if (SEED_RST == '0) begin : g_bad_seed
            $error("lfsr_keystream_gen: SEED_RST must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0]    state_q, state_d;
    logic [WIDTH-1:0]    seed_q,  seed_d;
    logic [WIDTH-1:0]    taps_q,  taps_d;
    logic [1:0]          fsm_q,   fsm_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [OUT_BITS-1:0] key_q,   key_d;
    logic                ph_q,    ph_d;

    logic                fb;
    logic [WIDTH-1:0]    state_step;
    logic [OUT_BITS-1:0] key_step;
    logic                step;
    logic [WIDTH-1:0]    taps_wr_val;
    logic                taps_wr_ok;

    // Next LFSR value always uses the taps currently held, so a same-cycle
    // TapsWr only affects later steps.
    assign fb         = ^(taps_q & state_q);
    assign state_step = {state_q[WIDTH-2:0], fb};

    // The first generated bit of a word ends up at its MSB.
    generate
        if (OUT_BITS == 1) begin : g_key_single
            assign key_step = fb;
        end else begin : g_key_shift
            assign key_step = {key_q[OUT_BITS-2:0], fb};
        end
    endgenerate

`ifdef LFSR_TAP_TABLE_EN
    generate
        if (WIDTH != 7) begin : g_bad_table_width
            $error("lfsr_keystream_gen: LFSR_TAP_TABLE_EN requires WIDTH == 7");
        end
    endgenerate

    // Only the low nibble selects a table entry.
    logic unused_taps_hi;
    assign unused_taps_hi = ^TapsIn[WIDTH-1:4];

    // Preset tap table lookup; out-of-range indices leave the taps alone.
    always_comb begin
        taps_wr_val = taps_q;
        taps_wr_ok  = 1'b1;
        case (TapsIn[3:0])
            4'd0:    taps_wr_val = WIDTH'(7'h60);
            4'd1:    taps_wr_val = WIDTH'(7'h48);
            4'd2:    taps_wr_val = WIDTH'(7'h78);
            4'd3:    taps_wr_val = WIDTH'(7'h72);
            4'd4:    taps_wr_val = WIDTH'(7'h6A);
            4'd5:    taps_wr_val = WIDTH'(7'h69);
            4'd6:    taps_wr_val = WIDTH'(7'h5C);
            4'd7:    taps_wr_val = WIDTH'(7'h7E);
            4'd8:    taps_wr_val = WIDTH'(7'h7B);
            default: taps_wr_ok  = 1'b0;
        endcase
    end
`else
    assign taps_wr_val = TapsIn;
    assign taps_wr_ok  = 1'b1;
`endif

    // Word-assembly FSM, tap/seed updates and period detection.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        taps_d  = taps_q;
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        step    = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (Enable) begin
                    fsm_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // Enable low pauses the word: everything holds.
                if (Enable) begin
                    step    = 1'b1;
                    state_d = state_step;
                    key_d   = key_step;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        fsm_d = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                // Word is frozen until the consumer takes it.
                if (KeyReady) begin
                    cnt_d = '0;
                    fsm_d = Enable ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
                cnt_d = '0;
            end
        endcase

        ph_d = step && (state_step == seed_q);

        if (TapsWr && taps_wr_ok) begin
            taps_d = taps_wr_val;
        end

        // Load wins over any step and throws away the word in progress.
        if (Load) begin
            state_d = SeedIn;
            seed_d  = SeedIn;
            cnt_d   = '0;
            key_d   = '0;
            fsm_d   = ST_IDLE;
            ph_d    = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= SEED_RST;
            seed_q  <= SEED_RST;
            taps_q  <= TAPS_RST;
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            taps_q  <= taps_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            ph_q    <= ph_d;
        end
    end

    assign KeyValid  = (fsm_q == ST_VALID);
    assign KeyOut    = key_q;
    assign State     = state_q;
    assign Lockup    = (state_q == '0);
    assign PeriodHit = ph_q;

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// tb_lfsr_keystream_gen: directed test of lfsr_keystream_gen with default
// parameters (WIDTH=7, OUT_BITS=8). Works with or without LFSR_TAP_TABLE_EN.
module tb_lfsr_keystream_gen;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Enable;
    logic       Load;
    logic [6:0] SeedIn;
    logic       TapsWr;
    logic [6:0] TapsIn;
    logic       KeyReady;
    logic       KeyValid;
    logic [7:0] KeyOut;
    logic [6:0] State;
    logic       Lockup;
    logic       PeriodHit;

    int tests_run = 0;
    int tests_failed = 0;

    lfsr_keystream_gen dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Enable    (Enable),
        .Load      (Load),
        .SeedIn    (SeedIn),
        .TapsWr    (TapsWr),
        .TapsIn    (TapsIn),
        .KeyReady  (KeyReady),
        .KeyValid  (KeyValid),
        .KeyOut    (KeyOut),
        .State     (State),
        .Lockup    (Lockup),
        .PeriodHit (PeriodHit)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       do_load;
        logic [6:0] seed;
        logic       do_taps;
        logic [6:0] taps_raw;
        logic [3:0] taps_idx;
        logic [7:0] exp_word;
        logic [6:0] exp_state;
        logic       exp_lock;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] s);
        Load   = 1'b1;
        SeedIn = s;
        tick();
        Load   = 1'b0;
    endtask

    task automatic do_taps(input logic [6:0] raw, input logic [3:0] idx);
`ifdef LFSR_TAP_TABLE_EN
        TapsIn = {3'b000, idx};
`else
        TapsIn = raw;
`endif
        TapsWr = 1'b1;
        tick();
        TapsWr = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!KeyValid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic consume();
        KeyReady = 1'b1;
        Enable   = 1'b0;
        tick();
        KeyReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int steps;
        int hits;
        int first_hit;
        int second_hit;
        int cyc;
        int rises;
        int rise_a;
        int rise_b;
        logic [7:0] hold_key;
        logic [6:0] hold_state;
        logic [6:0] prev;
        logic kv_prev;

        // {load, seed, taps write, raw taps, table index, word, state, lockup}
        vecs[0] = '{1'b1, 7'h01, 1'b1, 7'h60, 4'd0, 8'h06, 7'h06, 1'b0};
        vecs[1] = '{1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 8'h14, 7'h14, 1'b0};
        vecs[2] = '{1'b1, 7'h7F, 1'b0, 7'h00, 4'd0, 8'h02, 7'h02, 1'b0};
        vecs[3] = '{1'b1, 7'h01, 1'b1, 7'h78, 4'd2, 8'h1F, 7'h1F, 1'b0};
        vecs[4] = '{1'b1, 7'h01, 1'b1, 7'h7B, 4'd8, 8'hAE, 7'h2E, 1'b0};
        vecs[5] = '{1'b1, 7'h00, 1'b1, 7'h60, 4'd0, 8'h00, 7'h00, 1'b1};
        vecs[6] = '{1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 8'h00, 7'h00, 1'b1};
        vecs[7] = '{1'b1, 7'h01, 1'b0, 7'h00, 4'd0, 8'h06, 7'h06, 1'b0};

        Reset_n  = 1'b0;
        Enable   = 1'b0;
        Load     = 1'b0;
        SeedIn   = '0;
        TapsWr   = 1'b0;
        TapsIn   = '0;
        KeyReady = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // Reset values.
        check("rst_state", State, 7'h01);
        check("rst_keyvalid", KeyValid, 1'b0);
        check("rst_keyout", KeyOut, 8'h00);
        check("rst_lockup", Lockup, 1'b0);
        check("rst_periodhit", PeriodHit, 1'b0);
        $display("[TB] reset state=0x%0h valid=%0b", State, KeyValid);

        // First word from reset taps, then 20 cycles of backpressure.
        Enable = 1'b1;
        wait_valid(n);
        check("first_word_latency", n, 9);
        check("first_word_key", KeyOut, 8'h06);
        check("first_word_state", State, 7'h06);
        hold_key   = KeyOut;
        hold_state = State;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (KeyOut !== hold_key || State !== hold_state || KeyValid !== 1'b1) bad++;
        end
        check("backpressure_hold_cycles_bad", bad, 0);
        consume();
        check("consume_drops_valid", KeyValid, 1'b0);
        $display("[TB] first word key=0x%0h after %0d cycles", hold_key, n);

        // Table-driven words.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_load) do_load(vecs[v].seed);
            if (vecs[v].do_taps) do_taps(vecs[v].taps_raw, vecs[v].taps_idx);
            Enable = 1'b1;
            wait_valid(n);
            check($sformatf("vec%0d_latency", v), n, 9);
            check($sformatf("vec%0d_key", v), KeyOut, vecs[v].exp_word);
            check($sformatf("vec%0d_state", v), State, vecs[v].exp_state);
            check($sformatf("vec%0d_lockup", v), Lockup, vecs[v].exp_lock);
            $display("[TB] vec %0d seed=0x%0h key=0x%0h state=0x%0h", v, vecs[v].seed, KeyOut, State);
            consume();
        end

        // Full period: PeriodHit once per 127 steps, first on step 127.
        do_load(7'h01);
        check("no_hit_on_load", PeriodHit, 1'b0);
        do_taps(7'h60, 4'd0);
        Enable   = 1'b1;
        KeyReady = 1'b1;
        prev = State;
        kv_prev = KeyValid;
        steps = 0;
        hits = 0;
        first_hit = -1;
        second_hit = -1;
        rises = 0;
        rise_a = 0;
        rise_b = 0;
        cyc = 0;
        while (steps < 260 && cyc < 400) begin
            tick();
            cyc++;
            if (State !== prev) steps++;
            prev = State;
            if (PeriodHit) begin
                hits++;
                if (hits == 1) first_hit = steps;
                if (hits == 2) second_hit = steps;
            end
            if (KeyValid && !kv_prev) begin
                rises++;
                if (rises == 2) rise_a = cyc;
                if (rises == 3) rise_b = cyc;
            end
            kv_prev = KeyValid;
        end
        check("period_steps_reached", steps >= 260, 1);
        check("period_hit_count", hits, 2);
        check("period_first_hit_step", first_hit, 127);
        check("period_second_hit_step", second_hit, 254);
        check("throughput_cycles_per_word", rise_b - rise_a, 9);
        $display("[TB] period hits=%0d first=%0d second=%0d", hits, first_hit, second_hit);
        Enable = 1'b0;
        tick();
        tick();
        KeyReady = 1'b0;

        // Enable low mid-word pauses; the word completes after the resume.
        do_load(7'h01);
        Enable = 1'b1;
        tick();
        tick();
        tick();
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pause_state", State, 7'h04);
        check("pause_keyvalid", KeyValid, 1'b0);
        Enable = 1'b1;
        wait_valid(n);
        check("pause_resume_latency", n, 6);
        check("pause_resume_key", KeyOut, 8'h06);
        $display("[TB] pause/resume key=0x%0h", KeyOut);
        consume();

        // Load after 3 steps of FILL discards the partial word.
        do_load(7'h01);
        Enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("midfill_state_before_load", State, 7'h08);
        do_load(7'h7F);
        check("midfill_load_state", State, 7'h7F);
        check("midfill_load_keyvalid", KeyValid, 1'b0);
        wait_valid(n);
        check("midfill_new_latency", n, 9);
        check("midfill_new_key", KeyOut, 8'h02);
        check("midfill_new_state", State, 7'h02);
        $display("[TB] load mid-fill new key=0x%0h", KeyOut);
        consume();

`ifdef LFSR_TAP_TABLE_EN
        // Out-of-range table index leaves the taps unchanged.
        do_taps(7'h7B, 4'd8);
        TapsIn = 7'd12;
        TapsWr = 1'b1;
        tick();
        TapsWr = 1'b0;
        do_load(7'h01);
        Enable = 1'b1;
        wait_valid(n);
        check("table_idx12_keeps_taps", KeyOut, 8'hAE);
        $display("[TB] table index 12 key=0x%0h", KeyOut);
        consume();
`endif

        // Asynchronous reset mid-word returns outputs at once and restores taps.
        do_load(7'h01);
        do_taps(7'h7B, 4'd8);
        Enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("prereset_state", State, 7'h0D);
        check("prereset_key", KeyOut, 8'h05);
        #2;
        Reset_n = 1'b0;
        Enable  = 1'b0;
        #1;
        check("async_rst_state", State, 7'h01);
        check("async_rst_key", KeyOut, 8'h00);
        check("async_rst_keyvalid", KeyValid, 1'b0);
        check("async_rst_periodhit", PeriodHit, 1'b0);
        tick();
        Reset_n = 1'b1;
        tick();
        Enable = 1'b1;
        wait_valid(n);
        check("post_rst_key_reset_taps", KeyOut, 8'h06);
        $display("[TB] reset mid-word, post-reset key=0x%0h", KeyOut);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
